// File: rtl/aes_host_sequencer.sv
// aes_host_sequencer
// Host-side sequencer for the AES wrapper's 4-bit control / 16-bit write /
// 8-bit read interface. A start request runs one full transaction:
// CONFIG, optional key load and key expansion, block load, process start,
// status polling and a 16-byte result readback. The result is presented on
// `result` with a one-cycle `done` pulse.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start             one-cycle request, taken only in IDLE
//   load_key          1 = write key and run key init, 0 = reuse expanded key
//   encdec            1 = encrypt, 0 = decrypt
//   keylen            0 = 128-bit key (in key[255:128]), 1 = 256-bit key
//   key, block        key and input block, latched on start
//   busy              transaction in progress
//   done              one-cycle completion pulse
//   error             one-cycle pulse with done on a status-poll timeout
//   result            last good result, held until the next good done
//   ctrl, wdata       registered control code / write data to the wrapper
//   rdata             wrapper data_out
module aes_host_sequencer #(
  parameter int unsigned POLL_DELAY = 4,
  parameter int unsigned TIMEOUT    = 1023,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         load_key,
  input  logic         encdec,
  input  logic         keylen,
  input  logic [255:0] key,
  input  logic [127:0] block,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [127:0] result,
  output logic [3:0]   ctrl,
  output logic [15:0]  wdata,
  input  logic [7:0]   rdata
);

  localparam logic [3:0] CTL_IDLE    = 4'd0;
  localparam logic [3:0] CTL_WR_BLK  = 4'd1;
  localparam logic [3:0] CTL_WR_KEY  = 4'd2;
  localparam logic [3:0] CTL_STATUS  = 4'd3;
  localparam logic [3:0] CTL_CONFIG  = 4'd4;
  localparam logic [3:0] CTL_START   = 4'd5;
  localparam logic [3:0] CTL_RESULT  = 4'd6;

  localparam logic [15:0] GAP_LAST   = 16'(POLL_DELAY - 1);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(RD_LAT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CONFIG, S_WR_KEY, S_INIT, S_GAP1, S_POLL_RDY, S_WR_BLK,
    S_NEXT, S_GAP2, S_POLL_VLD, S_READ, S_DRAIN, S_FIN
  } state_e;

  state_e         state, state_d;
  logic [15:0]    cnt, cnt_d;
  logic           err_d;
  logic [3:0]     ctrl_d;
  logic [15:0]    wdata_d;
  logic           busy_d, done_d;

  logic [255:0]   key_q;
  logic [127:0]   block_q;
  logic           load_key_q;

  logic [RD_LAT-1:0] rd_pipe;
  logic [3:0]     cap_idx, cap_idx_d;
  logic [127:0]   shadow, shadow_d;

  // Next state and per-state cycle counter.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    err_d   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_CONFIG;
          cnt_d   = '0;
        end
      end
      S_CONFIG: begin
        state_d = load_key_q ? S_WR_KEY : S_WR_BLK;
        cnt_d   = '0;
      end
      S_WR_KEY: begin
        if (cnt == 16'd15) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_INIT: begin
        state_d = S_GAP1;
        cnt_d   = '0;
      end
      S_GAP1: begin
        if (cnt == GAP_LAST) begin
          state_d = S_POLL_RDY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_POLL_RDY: begin
        if (rdata[0]) begin
          state_d = S_WR_BLK;
          cnt_d   = '0;
        end else if (cnt == TO_LAST) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_WR_BLK: begin
        if (cnt == 16'd7) begin
          state_d = S_NEXT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_NEXT: begin
        state_d = S_GAP2;
        cnt_d   = '0;
      end
      S_GAP2: begin
        if (cnt == GAP_LAST) begin
          state_d = S_POLL_VLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_POLL_VLD: begin
        if (rdata[1]) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else if (cnt == TO_LAST) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_READ: begin
        if (cnt == 16'd15) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_d = S_FIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so that ctrl/wdata are
  // registered yet line up with the state they belong to. CONFIG is only
  // entered from IDLE on start, so its word comes straight from the mode
  // inputs; the wdata register is what holds them for the transaction.
  always_comb begin
    ctrl_d  = CTL_IDLE;
    wdata_d = '0;
    case (state_d)
      S_CONFIG: begin
        ctrl_d  = CTL_CONFIG;
        wdata_d = {14'b0, keylen, encdec};
      end
      S_WR_KEY: begin
        ctrl_d  = CTL_WR_KEY;
        wdata_d = key_q[{~cnt_d[3:0], 4'hF} -: 16];
      end
      S_INIT: begin
        ctrl_d  = CTL_START;
        wdata_d = 16'h0001;
      end
      S_POLL_RDY, S_POLL_VLD: ctrl_d = CTL_STATUS;
      S_WR_BLK: begin
        ctrl_d  = CTL_WR_BLK;
        wdata_d = block_q[{~cnt_d[2:0], 4'hF} -: 16];
      end
      S_NEXT: begin
        ctrl_d  = CTL_START;
        wdata_d = 16'h0002;
      end
      S_READ:  ctrl_d = CTL_RESULT;
      default: ;
    endcase
    busy_d = !(state_d inside {S_IDLE, S_FIN});
    done_d = (state_d == S_FIN);
  end

  // Readback capture: rd_pipe tracks which cycles carry a returned byte,
  // RD_LAT cycles behind each RESULT_OUT control cycle.
  always_comb begin
    shadow_d  = shadow;
    cap_idx_d = cap_idx;
    if (state == S_IDLE && start) begin
      cap_idx_d = '0;
    end else if (rd_pipe[RD_LAT-1]) begin
      shadow_d[{~cap_idx, 3'b111} -: 8] = rdata;
      cap_idx_d = cap_idx + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ctrl       <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      result     <= '0;
      key_q      <= '0;
      block_q    <= '0;
      load_key_q <= 1'b0;
      rd_pipe    <= '0;
      cap_idx    <= '0;
      shadow     <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      ctrl    <= ctrl_d;
      wdata   <= wdata_d;
      busy    <= busy_d;
      done    <= done_d;
      error   <= err_d;
      cap_idx <= cap_idx_d;
      shadow  <= shadow_d;
      if (state == S_IDLE && start) begin
        key_q      <= key;
        block_q    <= block;
        load_key_q <= load_key;
      end
      rd_pipe[0] <= (ctrl == CTL_RESULT);
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
      // Only the normal DRAIN exit publishes; a timeout leaves result as is.
      if (state == S_DRAIN && state_d == S_FIN) begin
        result <= shadow_d;
      end
    end
  end

endmodule
